updown_counter_seg: RTL and testbench
=====================================

# updown_counter_seg

Parametrised up/down counter with synchronous load, enable, selectable wrap or saturate at the limits, and a registered terminal-count pulse. It drives two seven-segment glyph outputs: the low nibble of the count as a hex digit, and a direction glyph ('U' or 'd'). It is the next-generation replacement for the fixed 4-bit up/down counter on the board display path. Width and modulus are generic, and it adds behaviour the fixed counter lacks: enable, load, modulus, saturation, terminal count and a hex digit decode.

## Interface
- WIDTH, 4, counter width in bits; legal range 1..16.
- MAX, 2**WIDTH-1, top count value; legal range 1..2**WIDTH-1.

- c  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on the rising edge of c.
- en  input  1  count enable; one step per cycle while high.
- updown  input  1  direction: 0 = up, 1 = down.
- load  input  1  synchronous load of d.
- d  input  WIDTH  load value.
- sat  input  1  limit mode: 0 = wrap, 1 = saturate.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- seg  output  7  hex glyph of q[3:0]; bit order {g,f,e,d,c,b,a}; active-high (1 = lit).
- seg_dir  output  7  direction glyph, same encoding.

## Operation
- Priority at each rising edge of c: rst low, then load, then en, then hold.
- Reset (rst == 0) sets q = 0, tc = 0 and seg_dir = 'U' (7'h3E). seg then shows '0' (7'h3F).
- Load: q <= d. If d > MAX, q <= MAX. A load never asserts tc.
- Count up (en = 1, updown = 0):
  - q < MAX: q <= q + 1.
  - q == MAX and sat = 0: q <= 0.
  - q == MAX and sat = 1: q holds MAX.
- Count down (en = 1, updown = 1):
  - q > 0: q <= q - 1.
  - q == 0 and sat = 0: q <= MAX.
  - q == 0 and sat = 1: q holds 0.
- Out-of-range states (q > MAX) cannot occur after reset or load. If one is present, a count step in either direction goes to MAX.
- Arithmetic is WIDTH bits. Wrap is to the modulus MAX, not to 2**WIDTH.
- tc <= 1 for an enabled step taken while q is at the limit in the current direction (q == MAX going up, q == 0 going down), whether or not sat is set. Otherwise tc <= 0.
- In saturate mode with en held high at a limit, tc stays high every cycle.
- seg_dir <= 'U' (7'h3E) when updown = 0 and 'd' (7'h5E) when updown = 1. It updates every non-reset edge, independent of en and load.
- seg is a combinational decode of registered q[3:0]. For WIDTH < 4, q is zero-extended first.
- seg glyphs for 0..F: 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 77, 7C, 39, 5E, 79, 71.

## Timing
- q, tc and seg_dir change one cycle after the qualifying edge; latency from any input to these outputs is 1 cycle.
- seg follows q combinationally, so seg is valid in the same cycle as q. There is no extra register stage.
- A change of updown takes effect on the same edge: the step on that edge uses the new direction.
- Simultaneous load and en: load wins, no step is taken and tc is 0.
- Reset asserted mid-count: q is 0 on the next edge, and any pending tc is dropped (tc is 0 after that edge).
- The first edge with rst high counts normally from 0.

## Configuration
- UDCNT_SEG_EN defined:
  - seg and seg_dir are driven as described above.
- UDCNT_SEG_EN undefined:
  - The decode logic and the seg_dir register are not built.
  - seg and seg_dir are tied to 7'h00 (all segments dark).
  - Ports remain present; q and tc behaviour is identical.

## Test plan
- WIDTH = 4, MAX = 9, sat = 0, up, en = 1 for 12 cycles from reset: q goes 1..9, 0, 1, 2. tc is 1 only in the cycle after the 9 -> 0 step. seg follows 06 .. 6F, then 3F.
- MAX = 9, sat = 0, down from q = 0: q goes 9, 8, 7. tc is 1 once, after the 0 -> 9 step. seg_dir = 7'h5E.
- MAX = 9, sat = 1, up from 8 for 4 cycles: q goes 9, 9, 9, 9. tc is 1 in the cycles after each step taken at 9 (3 cycles).
- load = 1 with d = 4'hC while MAX = 9: q = 9 and tc = 0. Next, load = 1 and en = 1 with d = 3: q = 3, with no step taken.
- Count to q = 5, then drive rst = 0 for one edge while en = 1: q = 0, tc = 0, seg = 3F, seg_dir = 3E. Hold en low for 3 cycles: q stays 0.
- Build without UDCNT_SEG_EN and repeat the first scenario: q and tc are identical, and seg = seg_dir = 7'h00 throughout.

Source files
------------

// File: rtl/updown_counter_seg_if.sv
// Control/status bundle for updown_counter_seg: count controls in, count/glyphs out.
// WIDTH must match the WIDTH of the counter it is connected to.
interface updown_counter_seg_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             updown;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             sat;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic [6:0]       seg;
  logic [6:0]       seg_dir;

  modport master (
    output en, updown, load, d, sat,
    input  q, tc, seg, seg_dir
  );

  modport slave (
    input  en, updown, load, d, sat,
    output q, tc, seg, seg_dir
  );
endinterface

// File: rtl/updown_counter_seg.sv
// Modulus up/down counter with load, wrap/saturate, terminal-count pulse and 7-seg glyphs.
// Define UDCNT_SEG_EN to build the hex/direction glyph outputs; otherwise they are tied dark.
module updown_counter_seg #(
  parameter int WIDTH = 4,
  parameter int MAX   = 2**WIDTH-1
) (
  input  logic                 c,
  input  logic                 rst,
  updown_counter_seg_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             tc_reg, tc_next;

  always_comb begin
    q_next  = q_reg;
    tc_next = 1'b0;
    if (bus.load) begin
      q_next = (bus.d > MAX_V) ? MAX_V : bus.d;
    end else if (bus.en) begin
      // A stray state above the modulus recovers to MAX whatever the direction.
      if (q_reg > MAX_V) begin
        q_next = MAX_V;
      end else if (!bus.updown) begin
        if (q_reg == MAX_V) begin
          tc_next = 1'b1;
          q_next  = bus.sat ? MAX_V : '0;
        end else begin
          q_next = q_reg + WIDTH'(1);
        end
      end else begin
        if (q_reg == '0) begin
          tc_next = 1'b1;
          q_next  = bus.sat ? '0 : MAX_V;
        end else begin
          q_next = q_reg - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge c) begin
    if (!rst) begin
      q_reg  <= '0;
      tc_reg <= 1'b0;
    end else begin
      q_reg  <= q_next;
      tc_reg <= tc_next;
    end
  end

  assign bus.q  = q_reg;
  assign bus.tc = tc_reg;

`ifdef UDCNT_SEG_EN
  logic [3:0] nib;
  logic [6:0] seg_dir_reg;
  logic [6:0] seg_next;

  // Narrow counters are zero-extended into the displayed nibble.
  for (genvar gi = 0; gi < 4; gi++) begin : g_nib
    if (gi < WIDTH) begin : g_bit
      assign nib[gi] = q_reg[gi];
    end else begin : g_zero
      assign nib[gi] = 1'b0;
    end
  end

  always_comb begin
    seg_next = 7'h00;
    case (nib)
      4'h0: seg_next = 7'h3F;
      4'h1: seg_next = 7'h06;
      4'h2: seg_next = 7'h5B;
      4'h3: seg_next = 7'h4F;
      4'h4: seg_next = 7'h66;
      4'h5: seg_next = 7'h6D;
      4'h6: seg_next = 7'h7D;
      4'h7: seg_next = 7'h07;
      4'h8: seg_next = 7'h7F;
      4'h9: seg_next = 7'h6F;
      4'hA: seg_next = 7'h77;
      4'hB: seg_next = 7'h7C;
      4'hC: seg_next = 7'h39;
      4'hD: seg_next = 7'h5E;
      4'hE: seg_next = 7'h79;
      4'hF: seg_next = 7'h71;
      default: seg_next = 7'h00;
    endcase
  end

  always_ff @(posedge c) begin
    if (!rst) begin
      seg_dir_reg <= 7'h3E;
    end else begin
      seg_dir_reg <= bus.updown ? 7'h5E : 7'h3E;
    end
  end

  assign bus.seg     = seg_next;
  assign bus.seg_dir = seg_dir_reg;
`else
  assign bus.seg     = 7'h00;
  assign bus.seg_dir = 7'h00;
`endif

endmodule

// File: tb/tb_updown_counter_seg.sv
// Scoreboard bench for updown_counter_seg (WIDTH=4, MAX=9); expected glyphs follow UDCNT_SEG_EN.
module tb_updown_counter_seg;

  localparam int WIDTH = 4;
  localparam int MAX   = 9;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic [6:0] seg;
    logic [6:0] seg_dir;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_step = 0;
  int   tc_seen;

  exp_t exp_q[$];
  logic [6:0] glyph [16];

  // Reference model state
  int         m_q;
  logic [6:0] m_dir;

  updown_counter_seg_if #(.WIDTH(WIDTH)) bus ();

  updown_counter_seg #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .c   (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Drive one cycle, predict the result, then compare after the edge.
  task automatic step(input logic r, input logic e, input logic ud, input logic ld,
                      input logic s, input logic [3:0] dv);
    exp_t       ex;
    exp_t       got;
    logic [3:0] nib;
    int         m_tc;
    @(negedge clk);
    rst = r; bus.en = e; bus.updown = ud; bus.load = ld; bus.sat = s; bus.d = dv;
    m_tc = 0;
    if (!r) begin
      m_q = 0; m_dir = 7'h3E;
    end else begin
      m_dir = ud ? 7'h5E : 7'h3E;
      if (ld) begin
        m_q = (int'(dv) > MAX) ? MAX : int'(dv);
      end else if (e) begin
        if (!ud) begin
          if (m_q == MAX) begin m_tc = 1; m_q = s ? MAX : 0; end
          else m_q = m_q + 1;
        end else begin
          if (m_q == 0) begin m_tc = 1; m_q = s ? 0 : MAX; end
          else m_q = m_q - 1;
        end
      end
    end
    nib = 4'(m_q);
    ex.q  = nib;
    ex.tc = 1'(m_tc);
`ifdef UDCNT_SEG_EN
    ex.seg     = glyph[nib];
    ex.seg_dir = m_dir;
`else
    ex.seg     = 7'h00;
    ex.seg_dir = 7'h00;
`endif
    exp_q.push_back(ex);
    @(posedge clk);
    #1;
    got = '{q: bus.q, tc: bus.tc, seg: bus.seg, seg_dir: bus.seg_dir};
    ex  = exp_q.pop_front();
    n_step++;
    tc_seen += int'(got.tc);
    $display("step %0d rst=%0b en=%0b ud=%0b ld=%0b sat=%0b d=%0h -> q=%0h tc=%0b seg=%0h dir=%0h",
             n_step, r, e, ud, ld, s, dv, got.q, got.tc, got.seg, got.seg_dir);
    chk("q",       16'(got.q),       16'(ex.q));
    chk("tc",      16'(got.tc),      16'(ex.tc));
    chk("seg",     16'(got.seg),     16'(ex.seg));
    chk("seg_dir", 16'(got.seg_dir), 16'(ex.seg_dir));
  endtask

  initial begin
    glyph = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    m_q = 0; m_dir = 7'h3E; tc_seen = 0;
    rst = 1'b0; bus.en = 1'b0; bus.updown = 1'b0; bus.load = 1'b0; bus.sat = 1'b0; bus.d = '0;

    // Reset state
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Wrap up from 0 for 12 cycles: 1..9,0,1,2 with a single tc
    tc_seen = 0;
    repeat (12) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("wrap_up_tc_count", 16'(tc_seen), 16'd1);
    chk("wrap_up_final_q", 16'(bus.q), 16'd2);

    // Wrap down from 0: 9,8,7 with a single tc
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    tc_seen = 0;
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0);
    chk("wrap_down_tc_count", 16'(tc_seen), 16'd1);
    chk("wrap_down_final_q", 16'(bus.q), 16'd7);

    // Saturate up from 8: 9,9,9,9 with tc on the last three
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h8);
    tc_seen = 0;
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'h0);
    chk("sat_up_tc_count", 16'(tc_seen), 16'd3);

    // Saturate down at 0
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 4'h0);
    repeat (2) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4'h0);

    // Over-range load clamps, then load beats enable
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'hC);
    chk("load_clamp_q", 16'(bus.q), 16'd9);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3);
    chk("load_over_en_q", 16'(bus.q), 16'd3);

    // Count to 5, reset mid-count with en high, then idle
    repeat (2) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("mid_reset_q", 16'(bus.q), 16'd0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0);

    // Random mix, including direction changes on the stepping edge
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 5) == 0), 1'($urandom), 4'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
